// File: rtl/brom_fetch_pkg.sv
// Shared types and helpers for the boot-ROM fetch master.
//   brom_fetch_state_t : fetch FSM states
//   BROM_WORD_OFFSET   : byte-offset bits inside one 64-bit ROM word
//   BROM_WORD_BITS     : width of the useful part of a ROM response
//   word_select()      : picks the 32-bit instruction out of a 64-bit word
package brom_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } brom_fetch_state_t;

    localparam int BROM_WORD_OFFSET = 3;
    localparam int BROM_WORD_BITS   = 64;

    // Address bit 2 chooses the upper or lower instruction of the word.
    function automatic logic [31:0] word_select(input logic [BROM_WORD_BITS-1:0] word,
                                                input logic                      upper);
        return upper ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/brom_fetch_linebuf.sv
// One-entry line buffer holding the last 64-bit boot-ROM word.
//   clk, rstn   : clock, async active-low reset
//   lookup_tag  : line address to compare against the stored tag
//   hit         : buffer valid and tag matches lookup_tag
//   data        : stored 64-bit word
//   fill        : load fill_tag/fill_data and mark valid
//   invalidate  : clear valid; wins over a simultaneous fill
module brom_fetch_linebuf
    import brom_fetch_pkg::*;
#(
    parameter int TAG_WIDTH = 21
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [TAG_WIDTH-1:0]      lookup_tag,
    output logic                      hit,
    output logic [BROM_WORD_BITS-1:0] data,
    input  logic                      fill,
    input  logic [TAG_WIDTH-1:0]      fill_tag,
    input  logic [BROM_WORD_BITS-1:0] fill_data,
    input  logic                      invalidate
);

    logic                      valid_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic [BROM_WORD_BITS-1:0] data_q;

    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
        end
    end

    // NOTE: the data word has no reset; valid_q gates every use of it, so
    // resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (fill && !invalidate) begin
            data_q <= fill_data;
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign data = data_q;

endmodule

// File: rtl/brom_fetch_master.sv
// Initiator side of the boot-ROM request/response interface.
// Turns 32-bit fetches into 8-byte-aligned ROM requests, serves repeats of
// the same line from a one-entry buffer, and errors misaligned fetches and
// lost responses (timeout).
//   fetch_req_*   : core fetch request (valid/ready, byte address)
//   fetch_resp_*  : instruction response (valid/ready, data, error)
//   fetch_flush_i : invalidate buffer, abandon the fetch in flight
//   brom_req_*    : one-cycle request strobe and aligned address
//   brom_ready_i  : responder idle
//   brom_resp_*   : one-cycle response strobe and data ([63:0] used)
module brom_fetch_master
    import brom_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH      = 24,
    parameter int BROM_DATA_WIDTH = 128,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       fetch_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]      fetch_req_addr_i,
    output logic                       fetch_req_ready_o,
    output logic                       fetch_resp_valid_o,
    input  logic                       fetch_resp_ready_i,
    output logic [31:0]                fetch_resp_data_o,
    output logic                       fetch_resp_error_o,
    input  logic                       fetch_flush_i,
    output logic                       brom_req_valid_o,
    output logic [ADDR_WIDTH-1:0]      brom_req_address_o,
    input  logic                       brom_ready_i,
    input  logic [BROM_DATA_WIDTH-1:0] brom_resp_data_i,
    input  logic                       brom_resp_valid_i
);

    localparam int TAG_W = ADDR_WIDTH - BROM_WORD_OFFSET;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    brom_fetch_state_t state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;     // line address of the current fetch
    logic              sel_q, sel_d;     // address bit 2 of the current fetch
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;   // DRAIN: timeout error not yet consumed
    logic              quiet_q, quiet_d; // DRAIN: responder seen idle/answered

    logic                      buf_hit;
    logic [BROM_WORD_BITS-1:0] buf_data;
    logic                      buf_fill;
    logic                      accept;
    logic [BROM_WORD_BITS-1:0] brom_word;
    logic                      unused_resp_bits;

    assign brom_word        = brom_resp_data_i[BROM_WORD_BITS-1:0];
    assign unused_resp_bits = ^brom_resp_data_i[BROM_DATA_WIDTH-1:BROM_WORD_BITS];

    brom_fetch_linebuf #(.TAG_WIDTH(TAG_W)) u_linebuf (
        .clk        (clk),
        .rstn       (rstn),
        .lookup_tag (fetch_req_addr_i[ADDR_WIDTH-1:BROM_WORD_OFFSET]),
        .hit        (buf_hit),
        .data       (buf_data),
        .fill       (buf_fill),
        .fill_tag   (tag_q),
        .fill_data  (brom_word),
        .invalidate (fetch_flush_i)
    );

    assign fetch_req_ready_o  = (state_q == IDLE) & rstn & ~fetch_flush_i;
    assign accept             = fetch_req_valid_i & fetch_req_ready_o;
    // Gated by flush so an abandoned fetch never leaves an orphan request.
    assign brom_req_valid_o   = (state_q == REQ) & brom_ready_i & ~fetch_flush_i;
    assign brom_req_address_o = {tag_q, {BROM_WORD_OFFSET{1'b0}}};
    // A timeout error is presented from DRAIN while the stale response drains.
    assign fetch_resp_valid_o = ((state_q == RESP) | ((state_q == DRAIN) & pend_q))
                                & ~fetch_flush_i;
    assign fetch_resp_data_o  = data_q;
    assign fetch_resp_error_o = err_q;

    // NOTE: every variable is given a default first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        sel_d    = sel_q;
        data_d   = data_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        quiet_d  = quiet_q;
        buf_fill = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d = fetch_req_addr_i[ADDR_WIDTH-1:BROM_WORD_OFFSET];
                    sel_d = fetch_req_addr_i[2];
                    if (fetch_req_addr_i[1:0] != 2'b00) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else if (buf_hit) begin
                        state_d = RESP;
                        err_d   = 1'b0;
                        data_d  = word_select(buf_data, fetch_req_addr_i[2]);
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (fetch_flush_i) begin
                    state_d = IDLE;
                end else if (brom_req_valid_o) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (fetch_flush_i) begin
                    // Whatever the responder returns now belongs to nobody.
                    state_d = DRAIN;
                    pend_d  = 1'b0;
                    quiet_d = 1'b0;
                end else if (brom_resp_valid_i) begin
                    state_d  = RESP;
                    buf_fill = 1'b1;
                    err_d    = 1'b0;
                    data_d   = word_select(brom_word, sel_q);
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DRAIN;
                    pend_d  = 1'b1;
                    quiet_d = 1'b0;
                    err_d   = 1'b1;
                    data_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (fetch_flush_i || fetch_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Leave only once the error is consumed (or flushed) and the
                // responder has answered or gone idle.
                pend_d  = pend_q & ~fetch_resp_ready_i & ~fetch_flush_i;
                quiet_d = quiet_q | brom_resp_valid_i | brom_ready_i;
                if (!pend_d && quiet_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            tag_q   <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            quiet_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            quiet_q <= quiet_d;
        end
    end

endmodule

// File: tb/tb_brom_fetch_master.sv
// Self-checking bench for brom_fetch_master: directed scenarios plus a
// randomized fetch stream, checked against a line-buffer/ROM model.
module tb_brom_fetch_master;

    localparam int AW      = 24;
    localparam int DW      = 128;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fetch_req_valid_i;
    logic [AW-1:0] fetch_req_addr_i;
    logic          fetch_req_ready_o;
    logic          fetch_resp_valid_o;
    logic          fetch_resp_ready_i;
    logic [31:0]   fetch_resp_data_o;
    logic          fetch_resp_error_o;
    logic          fetch_flush_i;
    logic          brom_req_valid_o;
    logic [AW-1:0] brom_req_address_o;
    logic          brom_ready_i;
    logic [DW-1:0] brom_resp_data_i;
    logic          brom_resp_valid_i;

    brom_fetch_master #(
        .ADDR_WIDTH      (AW),
        .BROM_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .fetch_req_valid_i  (fetch_req_valid_i),
        .fetch_req_addr_i   (fetch_req_addr_i),
        .fetch_req_ready_o  (fetch_req_ready_o),
        .fetch_resp_valid_o (fetch_resp_valid_o),
        .fetch_resp_ready_i (fetch_resp_ready_i),
        .fetch_resp_data_o  (fetch_resp_data_o),
        .fetch_resp_error_o (fetch_resp_error_o),
        .fetch_flush_i      (fetch_flush_i),
        .brom_req_valid_o   (brom_req_valid_o),
        .brom_req_address_o (brom_req_address_o),
        .brom_ready_i       (brom_ready_i),
        .brom_resp_data_i   (brom_resp_data_i),
        .brom_resp_valid_i  (brom_resp_valid_i)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: ROM contents and the one-entry buffer.
    logic          m_valid = 1'b0;
    logic [20:0]   m_tag   = '0;
    logic [63:0]   m_word  = '0;

    // Responder controls and observations.
    logic          rom_silent = 1'b0;
    logic          late_go    = 1'b0;
    int            strobe_cnt = 0;
    logic [AW-1:0] last_strobe_addr = '0;

    function automatic logic [63:0] rom_word(input logic [AW-1:0] a);
        logic [20:0] line;
        line = a[AW-1:3];
        if (line == 21'h20) return 64'h11112222_33334444;
        return {8'hC0, 3'b000, line, 11'h5A5, ~line};
    endfunction

    function automatic logic [31:0] pick(input logic [63:0] w, input logic upper);
        return upper ? w[63:32] : w[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural responder: busy after a strobe, answers 5 cycles later
    // unless silenced, in which case it answers only when late_go is raised.
    initial begin
        brom_ready_i      = 1'b1;
        brom_resp_valid_i = 1'b0;
        brom_resp_data_i  = '0;
        forever begin
            @(negedge clk);
            if (rstn && brom_req_valid_o) begin
                strobe_cnt++;
                last_strobe_addr = brom_req_address_o;
                @(posedge clk);
                #1 brom_ready_i = 1'b0;
                if (rom_silent) begin
                    while (!late_go) @(posedge clk);
                    #1;
                end else begin
                    repeat (4) @(posedge clk);
                    #1;
                end
                brom_resp_valid_i = 1'b1;
                brom_resp_data_i  = {64'hDEAD_BEEF_0BAD_F00D, rom_word(last_strobe_addr)};
                @(posedge clk);
                #1;
                brom_resp_valid_i = 1'b0;
                brom_ready_i      = 1'b1;
            end
        end
    end

    // One complete fetch: issue, wait for the response, optionally stall
    // the consumer for 'hold' cycles, consume, and compare with the model.
    task automatic do_fetch(input logic [AW-1:0] a, input int hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_strobes;
        int          s0;
        int          n;
        logic [31:0] held_data;

        if (a[1:0] != 2'b00) begin
            exp_err = 1'b1; exp_data = '0; exp_lat = 1; exp_strobes = 0;
        end else if (m_valid && m_tag == a[AW-1:3]) begin
            exp_err = 1'b0; exp_data = pick(m_word, a[2]); exp_lat = 1; exp_strobes = 0;
        end else if (rom_silent) begin
            // One REQ cycle, TIMEOUT cycles in WAIT, then the error shows.
            exp_err = 1'b1; exp_data = '0; exp_lat = TIMEOUT + 2; exp_strobes = 1;
        end else begin
            // Strobe in the cycle after accept, response 6 cycles after it.
            exp_err = 1'b0; exp_data = pick(rom_word(a), a[2]); exp_lat = 7; exp_strobes = 1;
            m_valid = 1'b1; m_tag = a[AW-1:3]; m_word = rom_word(a);
        end

        s0 = strobe_cnt;
        @(posedge clk);
        #1;
        fetch_req_valid_i = 1'b1;
        fetch_req_addr_i  = a;
        @(negedge clk);
        check($sformatf("req_ready@%06h", a), 64'(fetch_req_ready_o), 64'd1);
        @(posedge clk);
        #1 fetch_req_valid_i = 1'b0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fetch_resp_valid_o && n < 200);

        check($sformatf("latency@%06h", a), 64'(n), 64'(exp_lat));
        check($sformatf("data@%06h", a), 64'(fetch_resp_data_o), 64'(exp_data));
        check($sformatf("error@%06h", a), 64'(fetch_resp_error_o), 64'(exp_err));
        check($sformatf("strobes@%06h", a), 64'(strobe_cnt - s0), 64'(exp_strobes));
        if (exp_strobes == 1)
            check($sformatf("brom_addr@%06h", a), 64'(last_strobe_addr), 64'({a[AW-1:3], 3'b000}));

        held_data = fetch_resp_data_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid@%06h", a), 64'(fetch_resp_valid_o), 64'd1);
            check($sformatf("hold_data@%06h", a), 64'(fetch_resp_data_o), 64'(held_data));
        end

        @(posedge clk);
        #1 fetch_resp_ready_i = 1'b1;
        @(posedge clk);
        #1 fetch_resp_ready_i = 1'b0;
        @(negedge clk);
        check($sformatf("valid_drop@%06h", a), 64'(fetch_resp_valid_o), 64'd0);
    endtask

    initial begin
        int seen;
        int n;
        logic [AW-1:0] ra;

        rstn               = 1'b0;
        fetch_req_valid_i  = 1'b0;
        fetch_req_addr_i   = '0;
        fetch_resp_ready_i = 1'b0;
        fetch_flush_i      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_req_ready", 64'(fetch_req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(fetch_resp_valid_o), 64'd0);
        check("rst_brom_valid", 64'(brom_req_valid_o), 64'd0);
        check("rst_brom_addr", 64'(brom_req_address_o), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(fetch_req_ready_o), 64'd1);

        // Cold miss, buffer hit on the other half, misaligned fetch.
        do_fetch(24'h000100, 0);
        do_fetch(24'h000104, 0);
        do_fetch(24'h000102, 0);

        // Lost response: timeout error, stale answer drained, line still missing.
        rom_silent = 1'b1;
        do_fetch(24'h000200, 2);
        rom_silent = 1'b0;
        check("drain_blocks_req", 64'(fetch_req_ready_o), 64'd0);
        late_go = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fetch_req_ready_o && n < 20);
        late_go = 1'b0;
        check("drain_exit", 64'(fetch_req_ready_o), 64'd1);
        do_fetch(24'h000200, 0);

        // Flush while waiting: the response must not surface, buffer invalid.
        @(posedge clk);
        #1;
        fetch_req_valid_i = 1'b1;
        fetch_req_addr_i  = 24'h000300;
        @(posedge clk);
        #1 fetch_req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        fetch_flush_i = 1'b1;
        m_valid       = 1'b0;
        @(negedge clk);
        fetch_flush_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (fetch_resp_valid_o) seen++;
        end
        check("flush_no_resp", 64'(seen), 64'd0);
        check("flush_idle", 64'(fetch_req_ready_o), 64'd1);
        do_fetch(24'h000200, 0);
        do_fetch(24'h000300, 0);

        // Stalled consumer: data and valid stay put for 10 cycles.
        do_fetch(24'h000304, 10);

        // Reset in the middle of WAIT.
        @(posedge clk);
        #1;
        fetch_req_valid_i = 1'b1;
        fetch_req_addr_i  = 24'h000400;
        @(posedge clk);
        #1 fetch_req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(fetch_req_ready_o), 64'd0);
        check("mid_rst_resp_valid", 64'(fetch_resp_valid_o), 64'd0);
        check("mid_rst_resp_data", 64'(fetch_resp_data_o), 64'd0);
        check("mid_rst_resp_err", 64'(fetch_resp_error_o), 64'd0);
        check("mid_rst_brom_valid", 64'(brom_req_valid_o), 64'd0);
        check("mid_rst_brom_addr", 64'(brom_req_address_o), 64'd0);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", 64'(fetch_req_ready_o), 64'd1);
        do_fetch(24'h000100, 0);

        // Randomized stream over a few lines, mostly aligned.
        for (int i = 0; i < 24; i++) begin
            ra = 24'($urandom_range(0, 5) + 32'h40) << 3;
            if ($urandom_range(0, 4) == 0)
                ra = ra + 24'($urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 1)
                ra = ra + 24'd4;
            do_fetch(ra, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
